ex_mem_stage: RTL and testbench

- Pipeline boundary directly downstream of the execute-stage ALU.
- Captures the ALU result and zero flag with the store data, destination register and control bits.
- Resolves branches from the zero flag, using the codebase rule that "zero means jump" for both BEQ (via SUB) and BGTZ (via ALUCtl 100).
- Presents the captured word to the memory stage through a 2-entry elastic buffer with valid/ready handshakes on both sides.

---
 rtl/ex_mem_stage_if.sv | 52 +++++
 rtl/ex_mem_stage.sv | 111 +++++++++++
 tb/tb_ex_mem_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// Bundle between the execute stage, the EX/MEM boundary and the memory stage.
// The master modport is the stage itself; the slave modport is its surroundings.
interface ex_mem_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] alu_res;
   logic          alu_zf;
   logic [DW-1:0] store_data;
   logic [DW-1:0] branch_target;
   logic [RW-1:0] rd;
   logic          ctl_reg_write;
   logic          ctl_mem_read;
   logic          ctl_mem_write;
   logic          ctl_mem_to_reg;
   logic          ctl_branch;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_alu_res;
   logic [DW-1:0] out_store_data;
   logic [RW-1:0] out_rd;
   logic          out_reg_write;
   logic          out_mem_read;
   logic          out_mem_write;
   logic          out_mem_to_reg;
   logic          pc_src;
   logic [DW-1:0] pc_target;
   logic          fwd_en;
   logic [RW-1:0] fwd_rd;
   logic [DW-1:0] fwd_data;

   modport master (
      input  flush, in_valid, alu_res, alu_zf, store_data, branch_target, rd,
             ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg, ctl_branch,
             out_ready,
      output in_ready, out_valid, out_alu_res, out_store_data, out_rd,
             out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
             pc_src, pc_target, fwd_en, fwd_rd, fwd_data
   );

   modport slave (
      output flush, in_valid, alu_res, alu_zf, store_data, branch_target, rd,
             ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg, ctl_branch,
             out_ready,
      input  in_ready, out_valid, out_alu_res, out_store_data, out_rd,
             out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
             pc_src, pc_target, fwd_en, fwd_rd, fwd_data
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: 2-entry elastic buffer (head + skid) with branch resolution.
//  state | meaning
//  EMPTY | no word buffered, in_ready=1
//  ONE   | head H valid, in_ready=1
//  TWO   | head H and skid S valid, in_ready=0
module ex_mem_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic            clk,
   input logic            rst,
   ex_mem_stage_if.master bus
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [DW-1:0] alu_res;
      logic [DW-1:0] store_data;
      logic [RW-1:0] rd;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
      logic          mem_to_reg;
   } word_t;

   state_t        state_q, state_d;
   word_t         h_q, s_q, in_word;
   logic          in_ready_q;
   logic          pc_src_q;
   logic [DW-1:0] pc_target_q;
   logic          accept, pop, taken;
   logic          load_h_in, load_h_s, load_s;

   assign in_word = {bus.alu_res, bus.store_data, bus.rd, bus.ctl_reg_write,
                     bus.ctl_mem_read, bus.ctl_mem_write, bus.ctl_mem_to_reg};

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = bus.out_valid & bus.out_ready;
   assign taken  = accept & bus.ctl_branch & bus.alu_zf & ~bus.flush;

   always_comb begin
      state_d   = state_q;
      load_h_in = 1'b0;
      load_h_s  = 1'b0;
      load_s    = 1'b0;
      // Flush wins over everything; a concurrent pop is still treated as consumed.
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d   = ONE;
                  load_h_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  state_d = TWO;
                  load_s  = 1'b1;
               end else if (accept && pop) begin
                  load_h_in = 1'b1;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d  = ONE;
                  load_h_s = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         h_q         <= '0;
         s_q         <= '0;
         pc_src_q    <= 1'b0;
         pc_target_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
         if (load_h_in)     h_q <= in_word;
         else if (load_h_s) h_q <= s_q;
         if (load_s)        s_q <= in_word;
         pc_src_q <= taken;
         if (taken)         pc_target_q <= bus.branch_target;
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = (state_q != EMPTY);
   assign bus.out_alu_res    = h_q.alu_res;
   assign bus.out_store_data = h_q.store_data;
   assign bus.out_rd         = h_q.rd;
   assign bus.out_reg_write  = h_q.reg_write;
   assign bus.out_mem_read   = h_q.mem_read;
   assign bus.out_mem_write  = h_q.mem_write;
   assign bus.out_mem_to_reg = h_q.mem_to_reg;
   assign bus.pc_src         = pc_src_q;
   assign bus.pc_target      = pc_target_q;
   assign bus.fwd_en         = bus.out_valid & h_q.reg_write & (h_q.rd != '0);
   assign bus.fwd_rd         = h_q.rd;
   assign bus.fwd_data       = h_q.alu_res;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: scenario tasks plus a scoreboard that checks every
// word leaving the stage against the words accepted, in order.
module tb_ex_mem_stage;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ex_mem_stage_if #(.DW(32), .RW(5)) bus ();

   ex_mem_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw, mr, mw, m2r;
   } word_t;

   word_t sb[$];

   // Scoreboard: observe handshakes at the falling edge, ahead of the edge that commits them.
   always @(negedge clk) begin
      word_t exp_w, got_w;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            got_w = {bus.out_alu_res, bus.out_store_data, bus.out_rd, bus.out_reg_write,
                     bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg};
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_pop unexpected word got=%h exp=none", got_w);
            end else begin
               exp_w = sb.pop_front();
               if (got_w !== exp_w) begin
                  errors++;
                  $display("FAIL sb_pop got=%h exp=%h", got_w, exp_w);
               end
            end
         end
         if (bus.flush) sb.delete();
         else if (bus.in_valid && bus.in_ready)
            sb.push_back({bus.alu_res, bus.store_data, bus.rd, bus.ctl_reg_write,
                          bus.ctl_mem_read, bus.ctl_mem_write, bus.ctl_mem_to_reg});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                      input logic br, input logic zf, input logic [31:0] tgt);
      bus.in_valid       = 1'b1;
      bus.alu_res        = res;
      bus.store_data     = res ^ 32'hA5A5_0000;
      bus.rd             = rd;
      bus.ctl_reg_write  = rw;
      bus.ctl_mem_read   = res[0];
      bus.ctl_mem_write  = res[1];
      bus.ctl_mem_to_reg = res[2];
      bus.ctl_branch     = br;
      bus.alu_zf         = zf;
      bus.branch_target  = tgt;
   endtask

   task automatic drain();
      int n = 0;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      while (bus.out_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL drain got valid=%0b pending=%0d exp valid=0 pending=0", bus.out_valid, sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      put(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", bus.in_ready); end
      checks++; if (bus.pc_src !== 1'b0 || bus.fwd_en !== 1'b0) begin errors++; $display("FAIL reset_pc_fwd got=%0b%0b exp=00", bus.pc_src, bus.fwd_en); end
      checks++; if (bus.out_alu_res !== 32'h0 || bus.pc_target !== 32'h0 || bus.out_reg_write !== 1'b0) begin
         errors++; $display("FAIL reset_data got=%h/%h/%0b exp=0/0/0", bus.out_alu_res, bus.pc_target, bus.out_reg_write); end
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      put(32'h0000_0010, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_alu_res !== 32'h10) begin errors++; $display("FAIL basic_out got=%0b/%h exp=1/00000010", bus.out_valid, bus.out_alu_res); end
      checks++; if (bus.fwd_en !== 1'b1 || bus.fwd_rd !== 5'd8 || bus.fwd_data !== 32'h10) begin errors++; $display("FAIL basic_fwd got=%0b/%0d/%h exp=1/8/00000010", bus.fwd_en, bus.fwd_rd, bus.fwd_data); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%0b exp=1", bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%0b exp=0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      put(32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      put(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%0b exp=0", bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_alu_res !== 32'h11) begin errors++; $display("FAIL bp_hold got=%0b/%h exp=1/00000011", bus.out_valid, bus.out_alu_res); end
      bus.out_ready = 1'b1;
      step();
      checks++; if (bus.out_alu_res !== 32'h22 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%0b/%h exp=1/00000022", bus.out_valid, bus.out_alu_res); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again got=%0b exp=1", bus.in_ready); end
      drain();
   endtask

   task automatic test_branch();
      bus.out_ready = 1'b1;
      put(32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0040_0020);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.pc_src !== 1'b1 || bus.pc_target !== 32'h0040_0020) begin errors++; $display("FAIL br_taken got=%0b/%h exp=1/00400020", bus.pc_src, bus.pc_target); end
      step();
      checks++; if (bus.pc_src !== 1'b0 || bus.pc_target !== 32'h0040_0020) begin errors++; $display("FAIL br_pulse got=%0b/%h exp=0/00400020", bus.pc_src, bus.pc_target); end
      put(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0040_0040);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.pc_src !== 1'b0 || bus.pc_target !== 32'h0040_0020) begin errors++; $display("FAIL br_not_taken got=%0b/%h exp=0/00400020", bus.pc_src, bus.pc_target); end
      drain();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      put(32'h31, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      put(32'h32, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      put(32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0050_0000);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pc_src !== 1'b0) begin
         errors++; $display("FAIL flush_two got v/r/pc=%0b%0b%0b exp=010", bus.out_valid, bus.in_ready, bus.pc_src); end
      // Flush in ONE, where the branch would otherwise be accepted.
      put(32'h41, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      put(32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0060_0000);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.pc_src !== 1'b0 || bus.pc_target !== 32'h0040_0020) begin
         errors++; $display("FAIL flush_one got v/pc=%0b%0b tgt=%h exp=00 tgt=00400020", bus.out_valid, bus.pc_src, bus.pc_target); end
      drain();
   endtask

   task automatic test_rd0();
      bus.out_ready = 1'b0;
      put(32'h33, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.fwd_en !== 1'b0) begin errors++; $display("FAIL rd0_fwd got v/fwd=%0b%0b exp=10", bus.out_valid, bus.fwd_en); end
      drain();
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      put(32'h51, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      put(32'h52, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_hs got v/r=%0b%0b exp=01", bus.out_valid, bus.in_ready); end
      checks++; if (bus.out_alu_res !== 32'h0 || bus.out_reg_write !== 1'b0 || bus.fwd_en !== 1'b0 || bus.pc_target !== 32'h0) begin
         errors++; $display("FAIL arst_data got=%h/%0b/%0b/%h exp=0/0/0/0", bus.out_alu_res, bus.out_reg_write, bus.fwd_en, bus.pc_target); end
      sb.delete();
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      put(32'h44, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_alu_res !== 32'h44) begin errors++; $display("FAIL arst_first got=%0b/%h exp=1/00000044", bus.out_valid, bus.out_alu_res); end
      drain();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         put($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'b0, 1'b0, 32'h0);
         step();
         checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stream i=%0d got r/v=%0b%0b exp=11", i, bus.in_ready, bus.out_valid); end
      end
      for (int i = 0; i < 40; i++) begin
         bus.out_ready = 1'($urandom);
         if ($urandom_range(0, 3) != 0) put($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'b0, 1'b0, 32'h0);
         else bus.in_valid = 1'b0;
         step();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_branch();
      test_flush();
      test_rd0();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
